lb_window_ctrl: RTL and testbench

Controller on the read side of the line-buffer subsystem. Accepts the incoming 8-bit pixel stream, writes it round-robin into four line stores, and once three full lines are held, reads them out as 3x3 pixel windows (72 bits per beat) to the convolution stage. Sits between the DMA/stream input and the 3x3 kernel. Raises a one-cycle interrupt each time a line is consumed and its store is freed.

---
 rtl/lb_pkg.sv | 15 +
 rtl/lb_line_store.sv | 42 ++++
 rtl/lb_window_ctrl.sv | 152 +++++++++++++++
 tb/tb_lb_window_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types and constants for the line-buffer window controller.
package lb_pkg;

    localparam int PIX_W   = 8;
    localparam int N_LINES = 4;
    localparam int WIN_W   = 9 * PIX_W;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

endpackage

// File: rtl/lb_line_store.sv
// One line store: synchronous write port plus a combinational 3-tap read
// of columns a, a+1, a+2 (wrapping at LINE_W).
module lb_line_store
    import lb_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int AW     = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  pixel_t             i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [3*PIX_W-1:0] o_taps
);

    pixel_t mem [LINE_W];

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [1:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + (AW+1)'(k);
        if (s >= (AW+1)'(LINE_W)) begin
            s = s - (AW+1)'(LINE_W);
        end
        return s[AW-1:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    logic [AW-1:0] addr1, addr2;

    always_comb begin
        addr1  = wrap_add(i_raddr, 2'd1);
        addr2  = wrap_add(i_raddr, 2'd2);
        o_taps = {mem[i_raddr], mem[addr1], mem[addr2]};
    end

endmodule

// File: rtl/lb_window_ctrl.sv
// Writes the pixel stream round-robin into four line stores and emits 3x3
// windows once three lines are held. Optional macro: LB_CTRL_STATS_EN.
module lb_window_ctrl
    import lb_pkg::*;
#(
    parameter int LINE_W = 512
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_valid,
    output logic             o_pixel_ready,
    output logic [WIN_W-1:0] o_window,
    output logic             o_window_valid,
    input  logic             i_window_ready,
`ifdef LB_CTRL_STATS_EN
    output logic [15:0]      o_lines_done,
`endif
    output logic             o_intr
);

    localparam int            AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(LINE_W - 1);

    state_t             state_q, state_d;
    logic [1:0]         wr_sel_q, wr_sel_d;
    logic [1:0]         rd_sel_q, rd_sel_d;
    logic [AW-1:0]      wr_col_q, wr_col_d;
    logic [AW-1:0]      rd_col_q, rd_col_d;
    logic [2:0]         lines_full_q, lines_full_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic               win_valid_q, win_valid_d;
    logic               intr_q, intr_d;

    logic               pix_accept, wr_last, rd_fire, rd_last;
    logic [1:0]         sel_mid, sel_bot;
    logic [N_LINES-1:0] store_we;
    logic [3*PIX_W-1:0] taps [N_LINES];

    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_store
        assign store_we[gi] = pix_accept && (wr_sel_q == 2'(gi));

        lb_line_store #(
            .LINE_W (LINE_W)
        ) u_store (
            .i_clk   (i_clk),
            .i_we    (store_we[gi]),
            .i_waddr (wr_col_q),
            .i_wdata (i_pixel_data),
            .i_raddr (rd_col_q),
            .o_taps  (taps[gi])
        );
    end

    assign o_pixel_ready  = (lines_full_q < 3'd4);
    assign o_window       = window_q;
    assign o_window_valid = win_valid_q;
    assign o_intr         = intr_q;

    always_comb begin
        pix_accept   = i_pixel_valid && o_pixel_ready;
        wr_last      = pix_accept && (wr_col_q == COL_LAST);
        rd_fire      = (state_q == ST_READ) && (!win_valid_q || i_window_ready);
        rd_last      = rd_fire && (rd_col_q == COL_LAST);
        sel_mid      = rd_sel_q + 2'd1;
        sel_bot      = rd_sel_q + 2'd2;

        wr_col_d     = wr_col_q;
        wr_sel_d     = wr_sel_q;
        rd_col_d     = rd_col_q;
        rd_sel_d     = rd_sel_q;
        lines_full_d = lines_full_q;
        state_d      = state_q;
        window_d     = window_q;
        win_valid_d  = win_valid_q;
        intr_d       = rd_last;

        if (pix_accept) begin
            wr_col_d = wr_last ? '0 : wr_col_q + AW'(1);
            if (wr_last) begin
                wr_sel_d = wr_sel_q + 2'd1;
            end
        end

        // A write-side completion and a read-side release in the same cycle cancel.
        case ({wr_last, rd_last})
            2'b10:   lines_full_d = lines_full_q + 3'd1;
            2'b01:   lines_full_d = lines_full_q - 3'd1;
            default: lines_full_d = lines_full_q;
        endcase

        case (state_q)
            ST_IDLE: if (lines_full_q >= 3'd3) state_d = ST_READ;
            ST_READ: if (rd_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (rd_fire) begin
            window_d    = {taps[rd_sel_q], taps[sel_mid], taps[sel_bot]};
            win_valid_d = 1'b1;
            rd_col_d    = rd_last ? '0 : rd_col_q + AW'(1);
            if (rd_last) begin
                rd_sel_d = rd_sel_q + 2'd1;
            end
        end else if (i_window_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            wr_col_q     <= '0;
            rd_col_q     <= '0;
            lines_full_q <= '0;
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_col_q     <= wr_col_d;
            rd_col_q     <= rd_col_d;
            lines_full_q <= lines_full_d;
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            intr_q       <= intr_d;
        end
    end

`ifdef LB_CTRL_STATS_EN
    logic [15:0] lines_done_q, lines_done_d;

    always_comb begin
        lines_done_d = lines_done_q + {15'd0, intr_q};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lines_done_q <= '0;
        end else begin
            lines_done_q <= lines_done_d;
        end
    end

    assign o_lines_done = lines_done_q;
`endif

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Self-checking bench for lb_window_ctrl (LINE_W = 8) with a line-history
// reference model and per-cycle scoreboard.
`timescale 1ns/1ps
module tb_lb_window_ctrl;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [7:0]  i_pixel_data = '0;
    logic        i_pixel_valid = 1'b0;
    logic        o_pixel_ready;
    logic [71:0] o_window;
    logic        o_window_valid;
    logic        i_window_ready = 1'b0;
    logic        o_intr;
`ifdef LB_CTRL_STATS_EN
    logic [15:0] o_lines_done;
`endif

    always #5 clk = ~clk;

    lb_window_ctrl #(.LINE_W(LW)) dut (
        .i_clk          (clk),
        .i_rstn         (i_rstn),
        .i_pixel_data   (i_pixel_data),
        .i_pixel_valid  (i_pixel_valid),
        .o_pixel_ready  (o_pixel_ready),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .i_window_ready (i_window_ready),
`ifdef LB_CTRL_STATS_EN
        .o_lines_done   (o_lines_done),
`endif
        .o_intr         (o_intr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: every accepted pixel indexed by (line, column).
    logic [7:0]  pix_hist [0:127][0:LW-1];
    int          wl = 0, wc = 0, win_idx = 0, intr_cnt = 0;
    bit          prev_stall = 0, prev_intr = 0;
    logic [71:0] prev_win = '0;
    int          sent = 0;

    function automatic logic [71:0] exp_win(input int n);
        int k, c;
        logic [71:0] w;
        k = n / LW;
        c = n % LW;
        w = '0;
        if (k + 2 < 128) begin
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++)
                    w = {w[63:0], pix_hist[k + r][(c + j) % LW]};
        end
        return w;
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'((i / LW) * 16 + (i % LW));
    endfunction

    always @(negedge clk) begin
        if (!i_rstn) begin
            wl = 0; wc = 0; win_idx = 0; intr_cnt = 0;
            prev_stall = 0; prev_intr = 0;
        end else begin
            if (o_intr) intr_cnt++;
            n_checks++;
            if (o_pixel_ready !== ((wl - intr_cnt) < 4)) begin
                n_errors++;
                $display("FAIL pixel_ready: got %b required %b (lines written %0d, consumed %0d)",
                         o_pixel_ready, ((wl - intr_cnt) < 4), wl, intr_cnt);
            end
            if (prev_stall) begin
                n_checks++;
                if (o_window_valid !== 1'b1 || o_window !== prev_win) begin
                    n_errors++;
                    $display("FAIL hold_stable: got valid=%b win=%h required valid=1 win=%h",
                             o_window_valid, o_window, prev_win);
                end
            end
            if (o_window_valid) begin
                n_checks++;
                if (o_window !== exp_win(win_idx)) begin
                    n_errors++;
                    $display("FAIL window[%0d]: got %h required %h", win_idx, o_window, exp_win(win_idx));
                end
            end
            if (o_intr) begin
                n_checks++;
                if (prev_intr || !o_window_valid || (win_idx % LW) != LW - 1) begin
                    n_errors++;
                    $display("FAIL intr_timing: got prev_intr=%b valid=%b win_idx=%0d required 0/1/col %0d",
                             prev_intr, o_window_valid, win_idx, LW - 1);
                end
            end
            prev_stall = o_window_valid && !i_window_ready;
            prev_win   = o_window;
            prev_intr  = o_intr;
            if (o_window_valid && i_window_ready) win_idx++;
            if (i_pixel_valid && o_pixel_ready && wl < 128) begin
                pix_hist[wl][wc] = i_pixel_data;
                wc++;
                if (wc == LW) begin
                    wc = 0;
                    wl++;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        i_rstn = 1'b0;
        i_pixel_valid = 1'b0;
        i_window_ready = 1'b0;
        sent = 0;
        repeat (2) @(posedge clk);
        #1 i_rstn = 1'b1;
    endtask

    task automatic send_pixels(input int n, input bit rnd);
        bit acc;
        for (int i = 0; i < n; i++) begin
            i_pixel_data  = rnd ? 8'($urandom) : pat(sent);
            i_pixel_valid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 500 && !acc; w++) begin
                @(negedge clk);
                acc = o_pixel_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: got no accept for pixel %0d required accept", sent);
            end
            sent++;
        end
        i_pixel_valid = 1'b0;
    endtask

    task automatic wait_windows(input int n);
        for (int c = 0; c < 3000 && win_idx < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++;
        if (o_window !== '0 || o_window_valid !== 1'b0 || o_intr !== 1'b0 || o_pixel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_init: got win=%h v=%b intr=%b rdy=%b required 0/0/0/1",
                     o_window, o_window_valid, o_intr, o_pixel_ready);
        end
        #1 i_rstn = 1'b1;
        i_window_ready = 1'b1;
        send_pixels(28, 0);
        repeat (4) @(posedge clk);
        #3 i_rstn = 1'b0;
        #1;
        n_checks++;
        if (o_window !== '0 || o_window_valid !== 1'b0 || o_intr !== 1'b0 || o_pixel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_async: got win=%h v=%b intr=%b rdy=%b required 0/0/0/1",
                     o_window, o_window_valid, o_intr, o_pixel_ready);
        end
`ifdef LB_CTRL_STATS_EN
        n_checks++;
        if (o_lines_done !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_lines_done: got %0d required 0", o_lines_done);
        end
`endif
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        i_window_ready = 1'b1;
        send_pixels(24, 0);
        n_checks++;
        if (o_window_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_t: got valid=%b required 0", o_window_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_window_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_t1: got valid=%b required 0", o_window_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_window_valid !== 1'b1 || o_window !== 72'h000102_101112_202122) begin
            n_errors++;
            $display("FAIL first_window: got v=%b %h required v=1 000102101112202122", o_window_valid, o_window);
        end
        wait_windows(7);
        n_checks++;
        if (o_window_valid !== 1'b1 || o_window !== 72'h070001_171011_272021) begin
            n_errors++;
            $display("FAIL last_window: got v=%b %h required v=1 070001171011272021", o_window_valid, o_window);
        end
        wait_windows(8);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (win_idx != 8 || intr_cnt != 1) begin
            n_errors++;
            $display("FAIL basic_count: got windows=%0d intr=%0d required 8/1", win_idx, intr_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] held;
        do_reset();
        i_window_ready = 1'b1;
        send_pixels(24, 0);
        wait_windows(3);
        i_window_ready = 1'b0;
        held = o_window;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (o_window_valid !== 1'b1 || o_window !== held) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got v=%b %h required v=1 %h", i, o_window_valid, o_window, held);
            end
        end
        i_window_ready = 1'b1;
        wait_windows(8);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (win_idx != 8 || intr_cnt != 1) begin
            n_errors++;
            $display("FAIL bp_count: got windows=%0d intr=%0d required 8/1", win_idx, intr_cnt);
        end
    endtask

    task automatic test_full();
        int  accepts;
        bit  acc, seen, bad;
        do_reset();
        i_window_ready = 1'b0;
        i_pixel_valid  = 1'b1;
        accepts = 0;
        for (int c = 0; c < 200 && accepts < 32; c++) begin
            i_pixel_data = pat(accepts);
            @(negedge clk); acc = o_pixel_ready;
            @(posedge clk); #1;
            if (acc) accepts++;
        end
        n_checks++;
        if (accepts != 32 || o_pixel_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stop: got accepts=%0d rdy=%b required 32/0", accepts, o_pixel_ready);
        end
        for (int c = 0; c < 10; c++) begin
            i_pixel_data = pat(accepts);
            @(negedge clk); acc = o_pixel_ready;
            @(posedge clk); #1;
            if (acc) accepts++;
        end
        n_checks++;
        if (accepts != 32) begin
            n_errors++;
            $display("FAIL full_hold: got accepts=%0d required 32", accepts);
        end
        i_window_ready = 1'b1;
        seen = 0;
        bad  = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            i_pixel_data = pat(accepts);
            @(negedge clk); acc = o_pixel_ready;
            @(posedge clk); #1;
            if (acc) accepts++;
            if (o_intr) seen = 1;
            else if (o_pixel_ready) bad = 1;
        end
        n_checks++;
        if (!seen || bad || o_pixel_ready !== 1'b1 || win_idx != 7 || accepts != 32) begin
            n_errors++;
            $display("FAIL full_release: got intr=%b early=%b rdy=%b windows=%0d accepts=%0d required 1/0/1/7/32",
                     seen, bad, o_pixel_ready, win_idx, accepts);
        end
        for (int c = 0; c < 200 && accepts < 40; c++) begin
            i_pixel_data = pat(accepts);
            @(negedge clk); acc = o_pixel_ready;
            @(posedge clk); #1;
            if (acc) accepts++;
        end
        i_pixel_valid = 1'b0;
        wait_windows(24);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (accepts != 40 || win_idx != 24 || intr_cnt != 3) begin
            n_errors++;
            $display("FAIL full_drain: got accepts=%0d windows=%0d intr=%0d required 40/24/3",
                     accepts, win_idx, intr_cnt);
        end
    endtask

    task automatic test_concurrency();
        do_reset();
        i_window_ready = 1'b1;
        send_pixels(24, 0);
        @(posedge clk); #1;
        send_pixels(8, 0);
        n_checks++;
        if (o_intr !== 1'b1 || o_pixel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL conc_edge: got intr=%b rdy=%b required 1/1", o_intr, o_pixel_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_window_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL conc_bubble: got valid=%b required 0", o_window_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_window_valid !== 1'b1 || o_window !== 72'h101112_202122_303132 || o_pixel_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL conc_next: got v=%b %h rdy=%b required v=1 101112202122303132 rdy=1",
                     o_window_valid, o_window, o_pixel_ready);
        end
        wait_windows(16);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (win_idx != 16 || intr_cnt != 2) begin
            n_errors++;
            $display("FAIL conc_count: got windows=%0d intr=%0d required 16/2", win_idx, intr_cnt);
        end
    endtask

    task automatic test_random();
        bit done;
        do_reset();
        done = 0;
        fork
            begin
                for (int i = 0; i < 10 * LW; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_pixels(1, 1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    i_window_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        i_window_ready = 1'b1;
        wait_windows(64);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (win_idx != 64 || intr_cnt != 8) begin
            n_errors++;
            $display("FAIL random_count: got windows=%0d intr=%0d required 64/8", win_idx, intr_cnt);
        end
    endtask

`ifdef LB_CTRL_STATS_EN
    task automatic test_stats();
        do_reset();
        i_window_ready = 1'b1;
        send_pixels(7 * LW, 0);
        wait_windows(40);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (o_lines_done !== 16'd5) begin
            n_errors++;
            $display("FAIL lines_done: got %0d required 5", o_lines_done);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        $display("test_reset done: %0d checks, %0d errors", n_checks, n_errors);
        test_basic();
        $display("test_basic done: %0d checks, %0d errors", n_checks, n_errors);
        test_backpressure();
        $display("test_backpressure done: %0d checks, %0d errors", n_checks, n_errors);
        test_full();
        $display("test_full done: %0d checks, %0d errors", n_checks, n_errors);
        test_concurrency();
        $display("test_concurrency done: %0d checks, %0d errors", n_checks, n_errors);
        test_random();
        $display("test_random done: %0d checks, %0d errors", n_checks, n_errors);
`ifdef LB_CTRL_STATS_EN
        test_stats();
        $display("test_stats done: %0d checks, %0d errors", n_checks, n_errors);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
